// File: rtl/gte_microcode_sequencer.sv
// GTE microcode sequencer: walks the microcode ROM from a decoded start address,
// presents each word to the datapath, and ends on LAST, step watchdog or address wrap.
module gte_microcode_sequencer #(
  parameter int ADDR_W    = 9,
  parameter int UWORD_W   = 64,
  parameter int LAST_BIT  = 0,
  parameter int MAX_STEPS = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_isNop,
  input  logic [ADDR_W-1:0]  i_startAddr,
  input  logic               i_stall,
  output logic [ADDR_W-1:0]  o_romAddr,
  input  logic [UWORD_W-1:0] i_romData,
  output logic [UWORD_W-1:0] o_uWord,
  output logic               o_uValid,
  output logic [ADDR_W-1:0]  o_uPC,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_rejected
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [15:0]       WD_LIMIT = 16'(MAX_STEPS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_curAddr;
  logic [15:0]         r_stepCnt;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_rejected;

  logic                w_consume;
  logic                w_last;
  logic                w_wd;
  logic                w_wrap;
  logic                w_end;
  logic [ADDR_W-1:0]   w_romAddr;

  // End conditions are all judged on the word being consumed this cycle.
  always_comb begin
    w_consume = (r_state == ST_EXEC) && !i_stall;
    w_last    = i_romData[LAST_BIT];
    w_wd      = (r_stepCnt == WD_LIMIT);
    w_wrap    = (r_curAddr == {ADDR_W{1'b1}});
    w_end     = w_last | w_wd | w_wrap;
  end

  // ROM address: re-reads the current word while stalled so i_romData stays stable.
  always_comb begin
    w_romAddr = r_curAddr;
    case (r_state)
      ST_IDLE:  w_romAddr = i_startAddr;
      ST_FETCH: w_romAddr = r_curAddr;
      ST_EXEC: begin
        if (w_consume && !w_end) begin
          w_romAddr = r_curAddr + ADDR_ONE;
        end else begin
          w_romAddr = r_curAddr;
        end
      end
      default:  w_romAddr = r_curAddr;
    endcase
    if (i_rst) begin
      w_romAddr = {ADDR_W{1'b0}};
    end else begin
      w_romAddr = w_romAddr;
    end
  end

  // Sequencer FSM with registered status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_curAddr  <= {ADDR_W{1'b0}};
      r_stepCnt  <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rejected <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rejected <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            if (i_isNop) begin
              r_done <= 1'b1;
            end else begin
              r_curAddr <= i_startAddr;
              r_stepCnt <= 16'd0;
              r_busy    <= 1'b1;
              r_state   <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          r_rejected <= i_run;
          r_state    <= ST_EXEC;
        end
        ST_EXEC: begin
          r_rejected <= i_run;
          if (!i_stall) begin
            r_stepCnt <= r_stepCnt + 16'd1;
            if (w_end) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_err   <= !w_last & (w_wd | w_wrap);
            end else begin
              r_curAddr <= r_curAddr + ADDR_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_romAddr  = w_romAddr;
  assign o_uWord    = i_romData;
  assign o_uValid   = w_consume;
  assign o_uPC      = r_curAddr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rejected = r_rejected;

endmodule

// File: tb/tb_gte_microcode_sequencer.sv
// Directed bench for gte_microcode_sequencer with a synchronous ROM model.
module tb_gte_microcode_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_run;
  logic        i_isNop;
  logic [8:0]  i_startAddr;
  logic        i_stall;
  logic [8:0]  o_romAddr;
  logic [63:0] i_romData;
  logic [63:0] o_uWord;
  logic        o_uValid;
  logic [8:0]  o_uPC;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_rejected;

  logic [63:0] rom [0:511];
  int n_checks = 0;
  int n_pass   = 0;

  gte_microcode_sequencer #(
    .ADDR_W(9), .UWORD_W(64), .LAST_BIT(0), .MAX_STEPS(4)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_isNop(i_isNop),
    .i_startAddr(i_startAddr), .i_stall(i_stall), .o_romAddr(o_romAddr),
    .i_romData(i_romData), .o_uWord(o_uWord), .o_uValid(o_uValid),
    .o_uPC(o_uPC), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_rejected(o_rejected)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous ROM: data for the address presented now appears after the edge.
  always @(posedge i_clk) i_romData <= rom[o_romAddr];

  function automatic logic [63:0] mk(input logic [8:0] a, input logic last);
    return {16'hA5A5, 23'd0, a, 15'd0, last};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Check one cycle's outputs, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic v, input logic [8:0] pc,
                     input logic [8:0] ra, input logic busy, input logic done,
                     input logic err, input logic rej);
    #1;
    chk({tag, "/uValid"}, 64'(o_uValid), 64'(v));
    chk({tag, "/romAddr"}, 64'(o_romAddr), 64'(ra));
    chk({tag, "/busy"}, 64'(o_busy), 64'(busy));
    chk({tag, "/done"}, 64'(o_done), 64'(done));
    chk({tag, "/err"}, 64'(o_err), 64'(err));
    chk({tag, "/rejected"}, 64'(o_rejected), 64'(rej));
    if (v || i_stall) begin
      chk({tag, "/uPC"}, 64'(o_uPC), 64'(pc));
      chk({tag, "/uWord"}, o_uWord, rom[pc]);
    end
    @(posedge i_clk);
    #1;
  endtask

  // Start the 0x040..0x042 program and run it up to its last EXEC cycle.
  task automatic prog040(input string p);
    i_startAddr = 9'h040; i_run = 1'b1;
    cyc({p, ".run"},   1'b0, 9'h000, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0);
    i_run = 1'b0;
    cyc({p, ".fetch"}, 1'b0, 9'h000, 9'h040, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc({p, ".e0"},    1'b1, 9'h040, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc({p, ".e1"},    1'b1, 9'h041, 9'h042, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc({p, ".e2"},    1'b1, 9'h042, 9'h042, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_run = 1'b0; i_isNop = 1'b0; i_startAddr = 9'h000; i_stall = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = mk(9'(i), 1'b0);
    rom[9'h042] = mk(9'h042, 1'b1);
    rom[9'h000] = mk(9'h000, 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
    cyc("reset", 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    cyc("idle", 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic 3-word program; next run issued in the done cycle.
    prog040("t1");
    i_run = 1'b1;
    cyc("t1.done", 1'b0, 9'h000, 9'h040, 1'b0, 1'b1, 1'b0, 1'b0);
    i_run = 1'b0;

    // Back-to-back run with a 2-cycle stall on 0x041.
    cyc("t2.fetch", 1'b0, 9'h000, 9'h040, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t2.e0",    1'b1, 9'h040, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0);
    i_stall = 1'b1;
    cyc("t2.s0",    1'b0, 9'h041, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t2.s1",    1'b0, 9'h041, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0);
    i_stall = 1'b0;
    cyc("t2.e1",    1'b1, 9'h041, 9'h042, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t2.e2",    1'b1, 9'h042, 9'h042, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t2.done",  1'b0, 9'h000, 9'h040, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("t2.after", 1'b0, 9'h000, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0);

    // NOP: no walk, done pulses next cycle.
    i_startAddr = 9'h123; i_run = 1'b1; i_isNop = 1'b1;
    cyc("nop.run",   1'b0, 9'h000, 9'h123, 1'b0, 1'b0, 1'b0, 1'b0);
    i_run = 1'b0; i_isNop = 1'b0;
    cyc("nop.done",  1'b0, 9'h000, 9'h123, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("nop.after", 1'b0, 9'h000, 9'h123, 1'b0, 1'b0, 1'b0, 1'b0);

    // Watchdog after 4 words with no LAST.
    i_startAddr = 9'h100; i_run = 1'b1;
    cyc("wd.run",   1'b0, 9'h000, 9'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    i_run = 1'b0;
    cyc("wd.fetch", 1'b0, 9'h000, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("wd.e0",    1'b1, 9'h100, 9'h101, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("wd.e1",    1'b1, 9'h101, 9'h102, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("wd.e2",    1'b1, 9'h102, 9'h103, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("wd.e3",    1'b1, 9'h103, 9'h103, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("wd.done",  1'b0, 9'h000, 9'h100, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("wd.after", 1'b0, 9'h000, 9'h100, 1'b0, 1'b0, 1'b0, 1'b0);

    // Address wrap: abnormal end, then LAST on 0x1FF gives a normal end.
    for (int k = 0; k < 2; k++) begin
      if (k == 1) rom[9'h1FF] = mk(9'h1FF, 1'b1);
      i_startAddr = 9'h1FE; i_run = 1'b1;
      cyc("wrap.run",   1'b0, 9'h000, 9'h1FE, 1'b0, 1'b0, 1'b0, 1'b0);
      i_run = 1'b0;
      cyc("wrap.fetch", 1'b0, 9'h000, 9'h1FE, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("wrap.e0",    1'b1, 9'h1FE, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("wrap.e1",    1'b1, 9'h1FF, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("wrap.done",  1'b0, 9'h000, 9'h1FE, 1'b0, 1'b1, (k == 0), 1'b0);
    end

    // Run while busy is rejected and the original program completes.
    i_startAddr = 9'h040; i_run = 1'b1;
    cyc("rej.run",   1'b0, 9'h000, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0);
    i_run = 1'b0;
    cyc("rej.fetch", 1'b0, 9'h000, 9'h040, 1'b1, 1'b0, 1'b0, 1'b0);
    i_run = 1'b1; i_startAddr = 9'h100;
    cyc("rej.e0",    1'b1, 9'h040, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0);
    i_run = 1'b0; i_startAddr = 9'h040;
    cyc("rej.e1",    1'b1, 9'h041, 9'h042, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("rej.e2",    1'b1, 9'h042, 9'h042, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rej.done",  1'b0, 9'h000, 9'h040, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-EXEC: everything clears at once, no done, then a clean restart.
    i_run = 1'b1;
    cyc("mr.run",   1'b0, 9'h000, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0);
    i_run = 1'b0;
    cyc("mr.fetch", 1'b0, 9'h000, 9'h040, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mr.e0",    1'b1, 9'h040, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;
    cyc("mr.rst",   1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    cyc("mr.post",  1'b0, 9'h000, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0);
    prog040("mr.new");
    cyc("mr.done",  1'b0, 9'h000, 9'h040, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gte_microcode_sequencer.md
Name: gte_microcode_sequencer

Overview:
Consumes the 9-bit microcode start address produced by the GTE opcode-to-start-address decoder and walks the microcode ROM from that address. It issues ROM read addresses, presents each fetched microcode word with a valid strobe to the GTE datapath, and honours datapath stalls. It terminates on the word's LAST flag, on a step-count watchdog, or on address wrap. Sits between the GTE command interface, the start-address decoder and the synchronous microcode ROM.

Parameters:
ADDR_W, 9, microcode address width; matches the start-address decoder output.
UWORD_W, 64, microcode word width.
LAST_BIT, 0, bit index of the LAST (end-of-instruction) flag inside a microcode word.
MAX_STEPS, 64, maximum words executed per instruction before the watchdog fires; 1 to 2^16-1.

Ports:
i_clk  in  1  clock; all state on rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_run  in  1  start strobe; valid one cycle with i_startAddr and i_isNop.
i_isNop  in  1  command is a NOP; no ROM walk.
i_startAddr  in  ADDR_W  first microcode address, from the start-address decoder.
i_stall  in  1  datapath cannot accept the current word; hold it.
o_romAddr  out  ADDR_W  synchronous ROM read address; data returns next cycle on i_romData.
i_romData  in  UWORD_W  ROM read data.
o_uWord  out  UWORD_W  current microcode word; equals i_romData.
o_uValid  out  1  o_uWord is consumed this cycle.
o_uPC  out  ADDR_W  address of o_uWord.
o_busy  out  1  instruction in progress.
o_done  out  1  one-cycle pulse when an instruction ends, for any reason.
o_err  out  1  one-cycle pulse with o_done when the end is abnormal (watchdog or wrap).
o_rejected  out  1  one-cycle pulse when i_run arrives while busy.

Behaviour:
- Reset (asynchronous, any state, including mid-instruction): state=IDLE, curAddr=0, stepCnt=0. o_busy, o_done, o_err, o_rejected, o_uValid are all 0. o_romAddr=0. No partial completion pulse is generated.
- States: IDLE, FETCH, EXEC.
- IDLE:
  - o_romAddr = i_startAddr.
  - On i_run with !i_isNop: curAddr <= i_startAddr, stepCnt <= 0, o_busy <= 1, go to FETCH.
  - On i_run with i_isNop: stay IDLE. o_busy stays 0. o_done <= 1 next cycle, o_err <= 0.
- FETCH (one bubble cycle): o_romAddr = curAddr, o_uValid = 0. Next state is EXEC.
- EXEC:
  - o_uPC = curAddr, o_uWord = i_romData.
  - o_uValid = !i_stall.
  - o_romAddr = (!i_stall && !endCond) ? curAddr+1 : curAddr. When stalled, the same address is re-read, so i_romData is stable.
  - On !i_stall: stepCnt <= stepCnt+1.
  - If endCond: go to IDLE, o_busy <= 0, o_done <= 1 for one cycle.
  - Otherwise: curAddr <= curAddr+1.
- endCond (evaluated only in EXEC when !i_stall), each condition tested on the word being consumed:
  - last = i_romData[LAST_BIT].
  - wd = stepCnt == MAX_STEPS-1.
  - wrap = curAddr == all-ones.
  - endCond = last | wd | wrap.
  - o_err <= !last & (wd | wrap). When LAST coincides with wd or wrap, this is a normal end: o_err=0.
- Latency: i_run sampled at edge N, FETCH during cycle N+1, first o_uValid in cycle N+2. A K-word instruction with no stalls has o_uValid high for cycles N+2..N+K+1, o_done in cycle N+K+2, o_busy high in cycles N+1..N+K+1.
- Back-to-back: i_run is accepted in the cycle o_done is high, since the block is in IDLE then.
- i_run while state != IDLE: ignored, o_rejected <= 1 for one cycle. The current instruction is unaffected.
- i_stall outside EXEC: ignored.
- o_done, o_err and o_rejected are registered pulses; each lasts exactly one cycle.

Test Plan:
- Reset, then i_run with i_startAddr=0x040, ROM LAST at 0x042, no stall -> o_romAddr 0x040,0x040,0x041,0x042; o_uValid cycles N+2..N+4 with o_uPC 0x040,0x041,0x042; o_done at N+5; o_err=0.
- Same program with i_stall high for 2 cycles while o_uPC=0x041 -> o_uPC and o_uWord held 3 cycles, o_uValid low twice, o_romAddr holds 0x041; o_done delayed by 2 cycles.
- i_run with i_isNop=1 -> o_busy stays 0, o_done pulses next cycle, o_romAddr never leaves i_startAddr.
- MAX_STEPS=4, ROM with no LAST from 0x100 -> exactly 4 o_uValid (0x100..0x103), then o_done=1 and o_err=1.
- i_startAddr=0x1FE, LAST only at 0x000 -> words 0x1FE,0x1FF consumed, o_done and o_err at wrap; address 0x000 never consumed. Repeat with LAST at 0x1FF -> o_err=0.
- i_run during EXEC -> o_rejected one pulse, original sequence completes unchanged. Assert i_rst mid-EXEC -> all outputs 0 immediately, no o_done; a new i_run afterwards starts cleanly.
